median_result_packer: RTL

Downstream stage of the binary median-filter core. Consumes the serial 1-bit median stream (one result per `medianValid` strobe, raster order) and packs it LSB-first into bytes, row-aligned. Stores the bytes in an internal result RAM and flags frame completion. Provides a host-side read port for readback of the filtered image.

---
 rtl/median_pkg.sv | 28 ++
 rtl/median_byte_ram.sv | 33 +++
 rtl/median_result_packer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared types and sizing helpers for the binary median-filter core.
package median_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } packer_state_e;

  localparam int WINDOW_SIZE    = 3;
  localparam int MEDIAN_VALUE   = 4;

  // Default image is 256x256; the 3x3 window trims one pixel on each border.
  localparam int DEF_OUT_WIDTH  = 254;
  localparam int DEF_OUT_HEIGHT = 254;

  // Bytes per packed output row (partial last byte rounds up).
  function automatic int calc_bpr(input int out_width);
    return (out_width + 7) / 8;
  endfunction

  // Result RAM depth in bytes for a whole frame.
  function automatic int calc_depth(input int out_width, input int out_height);
    return calc_bpr(out_width) * out_height;
  endfunction

endpackage

// File: rtl/median_byte_ram.sv
// Simple dual-port byte RAM holding the packed median frame.
module median_byte_ram #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddress,
  input  logic [7:0]        wrData,
  input  logic [ADDR_W-1:0] rdAddress,
  output logic [7:0]        rdData
);

  logic [7:0] mem_q [DEPTH];

  // Write port; array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrAddress] <= wrData;
    end
  end

  // Registered read; a same-address write this edge is not yet visible (old data).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData <= '0;
    end else begin
      rdData <= mem_q[rdAddress];
    end
  end

endmodule

// File: rtl/median_result_packer.sv
// Packs the serial median bit stream LSB-first into row-aligned bytes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no frame yet; stray valids flag an overrun
//   S_COLLECT | packing pixels, committing bytes on byte/row boundaries
//   S_FLUSH   | early frame end: write any partial byte, then finish
//   S_DONE    | frame complete; hold until the next start
module median_result_packer
  import median_pkg::*;
#(
  parameter  int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter  int OUT_HEIGHT = DEF_OUT_HEIGHT,
  localparam int BPR        = calc_bpr(OUT_WIDTH),
  localparam int DEPTH      = calc_depth(OUT_WIDTH, OUT_HEIGHT),
  localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              medianValid,
  input  logic              medianDataIn,
  input  logic              fullImageDone,
  input  logic [ADDR_W-1:0] rdAddress,
  output logic [7:0]        rdData,
  output logic              busy,
  output logic              frameDone,
  output logic              shortFrameError,
  output logic              overrunError
);

  packer_state_e     state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [7:0]        shift_q, shift_d;
  logic              short_err_q, short_err_d;
  logic              overrun_err_q, overrun_err_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        shift_nxt;
  logic              last_col;
  logic              last_row;

  assign cur_addr  = ADDR_W'(int'(y_q) * BPR + int'(x_q[7:3]));
  assign shift_nxt = shift_q | (8'(medianDataIn) << x_q[2:0]);
  assign last_col  = (x_q == 8'(OUT_WIDTH - 1));
  assign last_row  = (y_q == 8'(OUT_HEIGHT - 1));

  // State, counters, shift register and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      shift_q       <= '0;
      short_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      shift_q       <= shift_d;
      short_err_q   <= short_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Next-state logic and byte commit decode; start overrides everything.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    shift_d       = shift_q;
    short_err_d   = short_err_q;
    overrun_err_d = overrun_err_q;
    wr_en         = 1'b0;
    wr_addr       = cur_addr;
    wr_data       = shift_nxt;

    if (start) begin
      state_d       = S_COLLECT;
      x_d           = '0;
      y_d           = '0;
      shift_d       = '0;
      short_err_d   = 1'b0;
      overrun_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (medianValid) overrun_err_d = 1'b1;
        end
        S_COLLECT: begin
          if (medianValid) begin
            shift_d = shift_nxt;
            if ((x_q[2:0] == 3'd7) || last_col) begin
              wr_en   = 1'b1;
              shift_d = '0;
            end
            if (last_col) begin
              x_d = '0;
              y_d = y_q + 8'd1;
              if (last_row) state_d = S_DONE;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
          // An end marker arriving with the final pixel is a clean finish.
          if (fullImageDone && !(medianValid && last_col && last_row)) begin
            state_d     = S_FLUSH;
            short_err_d = 1'b1;
          end
        end
        S_FLUSH: begin
          if (x_q[2:0] != 3'd0) begin
            wr_en   = 1'b1;
            wr_data = shift_q;
          end
          state_d = S_DONE;
        end
        S_DONE: begin
          if (medianValid) overrun_err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy            = (state_q == S_COLLECT) || (state_q == S_FLUSH);
  assign frameDone       = (state_q == S_DONE);
  assign shortFrameError = short_err_q;
  assign overrunError    = overrun_err_q;

  median_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (reset),
    .wrEn      (wr_en),
    .wrAddress (wr_addr),
    .wrData    (wr_data),
    .rdAddress (rdAddress),
    .rdData    (rdData)
  );

endmodule
